// File: rtl/arbitro2.sv
// Round-robin drain of four class FIFOs into one downstream FIFO, with a wrapping word counter.
// Latency: pop at cycle t gives push at t+2; back-to-back pops give back-to-back pushes.
// Backpressure: a pop is suppressed in the same cycle almost_full_out is high; words already in flight still drain.
module arbitro2 #(
   parameter int DATA_WIDTH = 6
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [3:0]            emptyFIFO,
   input  logic [DATA_WIDTH-1:0] data_in0,
   input  logic [DATA_WIDTH-1:0] data_in1,
   input  logic [DATA_WIDTH-1:0] data_in2,
   input  logic [DATA_WIDTH-1:0] data_in3,
   input  logic                  almost_full_out,
   output logic [3:0]            pop,
   output logic                  push,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  idle,
   output logic [7:0]            word_count
);

   localparam logic [1:0] INIT   = 2'd0;
   localparam logic [1:0] IDLE   = 2'd1;
   localparam logic [1:0] ACTIVE = 2'd2;
   localparam logic [1:0] STALL  = 2'd3;

   logic [1:0]            state;
   logic [1:0]            next_state;
   logic [1:0]            rr;
   logic [1:0]            grant_idx;
   logic                  any_ready;
   logic                  pop_en;
   logic                  s1_vld;
   logic [1:0]            s1_idx;
   logic [DATA_WIDTH-1:0] sel_dat;

   assign any_ready = (emptyFIFO != 4'b1111);
   assign pop_en    = (state != INIT) && !reset && !almost_full_out && any_ready;
   assign pop       = pop_en ? (4'b0001 << grant_idx) : 4'b0000;
   assign idle      = (state == IDLE) && !s1_vld && !push && !pop_en;

   // First non-empty FIFO at or after rr, wrapping 3 -> 0.
   always_comb begin
      logic       found;
      logic [1:0] idx;
      grant_idx = rr;
      found     = 1'b0;
      for (int i = 0; i < 4; i++) begin
         idx = rr + 2'(i);
         if (!found && !emptyFIFO[idx]) begin
            grant_idx = idx;
            found     = 1'b1;
         end
      end
   end

   // Next state: INIT lasts one cycle, afterwards follow the FIFO and backpressure status.
   always_comb begin
      next_state = state;
      if (state == INIT)
         next_state = IDLE;
      else if (!any_ready)
         next_state = IDLE;
      else if (almost_full_out)
         next_state = STALL;
      else
         next_state = ACTIVE;
   end

   // Read data of the FIFO popped last cycle.
   always_comb begin
      sel_dat = data_in0;
      case (s1_idx)
         2'd0: sel_dat = data_in0;
         2'd1: sel_dat = data_in1;
         2'd2: sel_dat = data_in2;
         2'd3: sel_dat = data_in3;
         default: sel_dat = data_in0;
      endcase
   end

   // State, round-robin pointer, two-stage pop-to-push pipeline and word counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= INIT;
         rr         <= 2'd0;
         s1_vld     <= 1'b0;
         s1_idx     <= 2'd0;
         push       <= 1'b0;
         data_out   <= '0;
         word_count <= 8'd0;
      end else begin
         state  <= next_state;
         s1_vld <= pop_en;
         if (pop_en) begin
            rr     <= grant_idx + 2'd1;
            s1_idx <= grant_idx;
         end
         push <= s1_vld;
         if (s1_vld)
            data_out <= sel_dat;
         if (push)
            word_count <= word_count + 8'd1;
      end
   end

endmodule

// File: tb/tb_arbitro2.sv
// Randomized bench for arbitro2: queue-based class FIFOs and a scheduled-push reference model.
// Latency: checks pop in the same cycle and pushes exactly two cycles after each modelled pop.
// Backpressure: almost_full_out is driven both in directed bursts and at random.
module tb_arbitro2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       af  = 1'b0;
   logic [3:0] empty_flags = 4'b1111;
   logic [5:0] din [4];
   logic [3:0] pop;
   logic       push;
   logic [5:0] data_out;
   logic       idle;
   logic [7:0] word_count;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;
   bit chk_on = 0;

   // Reference model state
   logic [5:0] q [4][$];
   int         due_q [$];
   logic [5:0] dat_q [$];
   int         m_rr = 0;
   int         m_cnt = 0;
   bit         m_init = 1;
   bit         m_idle_st = 0;

   always #5 clk = ~clk;

   arbitro2 #(.DATA_WIDTH(6)) dut (
      .clk(clk),
      .reset(rst),
      .emptyFIFO(empty_flags),
      .data_in0(din[0]),
      .data_in1(din[1]),
      .data_in2(din[2]),
      .data_in3(din[3]),
      .almost_full_out(af),
      .pop(pop),
      .push(push),
      .data_out(data_out),
      .idle(idle),
      .word_count(word_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic cycle();
      int         k;
      bit         anyne;
      logic [3:0] ep;
      bit         ep_push;
      bit         eidle;
      logic [5:0] w;
      for (int i = 0; i < 4; i++) empty_flags[i] = (q[i].size() == 0);
      @(negedge clk);
      anyne = 0;
      for (int i = 0; i < 4; i++) if (q[i].size() > 0) anyne = 1;
      k = -1;
      if (!m_init && !rst && !af && anyne)
         for (int i = 0; i < 4; i++)
            if (k < 0 && q[(m_rr + i) % 4].size() > 0) k = (m_rr + i) % 4;
      ep      = (k >= 0) ? 4'(1 << k) : 4'b0000;
      ep_push = (due_q.size() > 0) && (due_q[0] == cyc);
      eidle   = !m_init && m_idle_st && (due_q.size() == 0) && (k < 0);
      if (chk_on) begin
         chk("pop", pop, ep);
         chk("push", push, ep_push);
         if (ep_push) chk("data_out", data_out, dat_q[0]);
         chk("idle", idle, eidle);
         chk("word_count", word_count, m_cnt);
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) din[i] = 6'($urandom);
      if (rst) begin
         m_init    = 1;
         m_idle_st = 0;
         m_cnt     = 0;
         m_rr      = 0;
         due_q.delete();
         dat_q.delete();
      end else begin
         if (ep_push) begin
            m_cnt = (m_cnt + 1) % 256;
            void'(due_q.pop_front());
            void'(dat_q.pop_front());
         end
         if (k >= 0) begin
            w = q[k].pop_front();
            due_q.push_back(cyc + 2);
            dat_q.push_back(w);
            din[k] = w;
            m_rr = (k + 1) % 4;
         end
         m_idle_st = m_init ? 1'b1 : !anyne;
         m_init    = 0;
      end
      chk_on = 1;
      cyc++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      af  = 1'b0;
      for (int i = 0; i < 4; i++) q[i].delete();
      run(n);
      rst = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 4; i++) din[i] = 6'd0;

      // All FIFOs empty after reset
      do_reset(2);
      run(10);

      // One word in each FIFO
      q[0].push_back(6'h01);
      q[1].push_back(6'h12);
      q[2].push_back(6'h23);
      q[3].push_back(6'h34);
      run(8);
      chk("count_after_four", word_count, 4);

      // Only FIFO 2 with three words
      for (int i = 0; i < 3; i++) q[2].push_back(6'(8 + i));
      run(7);

      // Almost-full rising during a stream
      for (int i = 0; i < 6; i++) q[i % 4].push_back(6'($urandom));
      run(2);
      af = 1'b1;
      run(4);
      af = 1'b0;
      run(8);

      // Random stream with random backpressure and refills
      for (int c = 0; c < 250; c++) begin
         af = ($urandom_range(0, 4) == 0);
         if ($urandom_range(0, 1) == 1) begin
            int f;
            f = $urandom_range(0, 3);
            if (q[f].size() < 8) q[f].push_back(6'($urandom));
         end
         cycle();
      end
      af = 1'b0;
      run(40);

      // Reset one cycle after a pop
      do_reset(2);
      q[3].push_back(6'h2a);
      run(2);
      rst = 1'b1;
      run(1);
      rst = 1'b0;
      q[0].push_back(6'h05);
      q[1].push_back(6'h06);
      run(8);

      // 258 words through FIFO 1: counter wraps
      do_reset(2);
      for (int i = 0; i < 258; i++) q[1].push_back(6'(i));
      run(266);
      chk("wrap", word_count, 2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/arbitro2.md
# arbitro2

Egress-side arbiter that drains the four class FIFOs filled by `arbitro1` into one downstream FIFO. It pops the class FIFOs round-robin and registers the popped word. It pushes the word downstream two cycles after the pop and stops popping while the downstream FIFO is almost full. It also keeps a wrapping count of forwarded words and reports when it is idle.

## Interface
Parameters:
- `DATA_WIDTH`, 6, width of one FIFO word.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `emptyFIFO`  in  4  empty flags of class FIFOs 0..3.
- `data_in0`..`data_in3`  in  DATA_WIDTH each  read data of class FIFOs 0..3. Valid the cycle after that FIFO's pop.
- `almost_full_out`  in  1  downstream FIFO almost-full flag. Asserts while 2 or fewer entries are free.
- `pop`  out  4  one-hot pop to class FIFOs; all zero when not popping.
- `push`  out  1  write strobe to the downstream FIFO.
- `data_out`  out  DATA_WIDTH  word written downstream; qualified by `push`.
- `idle`  out  1  high when nothing is being popped or is in flight.
- `word_count`  out  8  number of words pushed since reset, modulo 256.

## Operation
- FSM states:
  - INIT: entered on reset.
  - IDLE: no candidate FIFO.
  - ACTIVE: popping.
  - STALL: `almost_full_out`=1 with a candidate pending.
- FSM transitions, evaluated every cycle:
  - INIT→IDLE unconditionally.
  - From IDLE, ACTIVE or STALL, the next state is:
    - IDLE if `emptyFIFO`==4'b1111;
    - STALL if `almost_full_out`=1 and `emptyFIFO`!=4'b1111;
    - ACTIVE otherwise.
- Pop decision is combinational and made in the same cycle:
  - A pop is issued when the state is not INIT, `reset`=0, `almost_full_out`=0, and at least one `emptyFIFO` bit is 0.
  - `pop` never drives more than one bit.
- Round-robin pointer `rr` (2 bits, reset 0):
  - The grant goes to the first non-empty FIFO searched from `rr` upward, wrapping 3→0.
  - After a grant to FIFO k, `rr` becomes (k+1) mod 4.
  - `rr` is unchanged when no pop is issued.
- Pipeline, for a pop at cycle t:
  - Stage 1 at t+1: register the valid bit and granted index; select `data_in[k]` and latch it.
  - Stage 2 at t+2: drive `push`=1 and `data_out`=the latched word.
  - Back-to-back pops give back-to-back pushes.
- `word_count` increments on every cycle with `push`=1 and wraps 255→0.
- `idle` = (state is IDLE) AND both pipeline valid bits are 0 AND no pop this cycle.

## Timing
- Reset values, one cycle after `reset` is sampled high:
  - `pop`=0, `push`=0, `data_out`=0, `word_count`=0, `idle`=0 (state INIT), `rr`=0.
  - Both pipeline stages are cleared.
- Latency from pop to push is exactly 2 cycles, with no bubbles.
- Throughput is 1 word per cycle while any FIFO is non-empty and `almost_full_out`=0.
- Almost-full handling:
  - `almost_full_out` is sampled combinationally: a pop is suppressed in the same cycle it goes high.
  - At most 2 words are in flight. They are still pushed, which is safe because of the 2-slot margin.
- Empty handling:
  - `emptyFIFO` reflects each FIFO's state after the previous edge.
  - Popping a FIFO's last word at t means its flag is 1 at t+1 and it is skipped.
- Simultaneous events:
  - All four FIFOs non-empty: grants go 0,1,2,3,0…
  - A FIFO that goes empty between grants is skipped.
- Reset mid-operation:
  - In-flight words are discarded; no `push` occurs after the reset edge.
  - `word_count` clears.
- First pop after reset is at the earliest in the second cycle with `reset`=0, since INIT lasts one cycle.

## Test plan
- Reset, then all FIFOs empty for 10 cycles:
  - `pop`=0, `push`=0, `word_count`=0 throughout.
  - `idle`=1 from the second cycle after reset deassertion.
- FIFOs 0..3 each hold one word (0x01,0x12,0x23,0x34), downstream never almost full:
  - `pop` = 0001,0010,0100,1000 on consecutive cycles.
  - `push` high for 4 cycles starting 2 cycles after the first pop, `data_out` = 0x01,0x12,0x23,0x34.
  - `word_count`=4.
- Only FIFO 2 non-empty with 3 words:
  - `pop`=0100 for 3 consecutive cycles.
  - 3 pushes in order, then `idle`=1.
- `almost_full_out` rises during a stream:
  - `pop`=0 in that same cycle; exactly the 2 in-flight words are still pushed, then `push`=0.
  - Popping resumes the cycle `almost_full_out` falls, continuing from `rr`.
- Assert `reset` one cycle after a pop:
  - No `push` ever appears for that word.
  - All outputs are 0 the next cycle and `rr` restarts at FIFO 0.
- Push 258 words through FIFO 1: `word_count` reads 2 after the wrap.
